fire_expand_sequencer: RTL and testbench

- Sequences one 1x1 expand layer (fire9_expand1-class MAC array) over a full feature map.
- Reads CHIN input channels per output pixel from the feature RAM and drives the layer's enable/pixel inputs with the exact beat cadence its internal clear counter expects: CHIN data beats plus one pad beat per pixel.
- Counts the layer's sample pulses to generate output-RAM write strobes and addresses, then reports completion with a done/ack handshake.
- Sits between the top-level layer scheduler and the expand layer instance.

---
 rtl/fire_expand_sequencer_if.sv | 33 +++
 rtl/fire_expand_sequencer.sv | 125 ++++++++++++
 tb/tb_fire_expand_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire_expand_sequencer_if.sv
// Scheduler/RAM/layer-facing signals of the fire expand sequencer.
// The sequencer uses the slave view; the scheduler/testbench side uses master.
interface fire_expand_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 13,
  parameter int PIX_W  = 7
);
  logic              start_i;
  logic              ifm_stall_i;
  logic              ifm_rd_en_o;
  logic [ADDR_W-1:0] ifm_rd_addr_o;
  logic [WIDTH-1:0]  ifm_rd_data_i;
  logic              layer_en_o;
  logic [WIDTH-1:0]  ifm_o;
  logic              layer_sample_i;
  logic              ofm_wr_en_o;
  logic [PIX_W-1:0]  ofm_wr_addr_o;
  logic              busy_o;
  logic              done_o;
  logic              done_ack_i;

  modport slave (
    input  start_i, ifm_stall_i, ifm_rd_data_i, layer_sample_i, done_ack_i,
    output ifm_rd_en_o, ifm_rd_addr_o, layer_en_o, ifm_o,
           ofm_wr_en_o, ofm_wr_addr_o, busy_o, done_o
  );

  modport master (
    output start_i, ifm_stall_i, ifm_rd_data_i, layer_sample_i, done_ack_i,
    input  ifm_rd_en_o, ifm_rd_addr_o, layer_en_o, ifm_o,
           ofm_wr_en_o, ofm_wr_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/fire_expand_sequencer.sv
// Streams CHIN channel beats plus one pad beat per pixel into a 1x1 expand layer,
// turns the layer's sample pulses into output-RAM writes and signals done/ack.
module fire_expand_sequencer #(
  parameter int WOUT   = 8,
  parameter int CHIN   = 112,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(WOUT*WOUT*CHIN),
  parameter int PIX_W  = $clog2(WOUT*WOUT)+1
) (
  input  logic                    clk,
  input  logic                    rst,
  fire_expand_sequencer_if.slave  bus
);

  localparam int NPIX = WOUT*WOUT;
  localparam int CH_W = $clog2(CHIN+1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [PIX_W-1:0]  r_pix;
  logic [CH_W-1:0]   r_ch;
  logic [PIX_W-1:0]  r_smp;
  logic [PIX_W-1:0]  r_wr_addr;
  logic              r_wr_en;
  logic              r_layer_en;
  logic              r_prev_rd;
  logic              r_busy;
  logic              r_done;

  logic              w_issue;
  logic              w_pad;
  logic              w_read;
  logic              w_take;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_ifm;

  assign w_issue = (r_state == S_STREAM) && !bus.ifm_stall_i;
  assign w_pad   = (r_ch == CH_W'(CHIN));
  assign w_read  = w_issue && !w_pad;
  assign w_addr  = ADDR_W'(r_pix) * ADDR_W'(CHIN) + ADDR_W'(r_ch);
  assign w_take  = bus.layer_sample_i
                && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                && (r_smp != PIX_W'(NPIX));

  // RAM data lands in the same cycle as the registered enable, so only the
  // select is registered; pad beats and stalled slots present zero.
  assign w_ifm = r_prev_rd ? bus.ifm_rd_data_i : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pix      <= '0;
      r_ch       <= '0;
      r_smp      <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_layer_en <= 1'b0;
      r_prev_rd  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_layer_en <= w_issue;
      r_prev_rd  <= w_read;
      r_wr_en    <= w_take;
      r_wr_addr  <= w_take ? r_smp : '0;
      if (w_take) begin
        r_smp <= r_smp + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
            r_pix   <= '0;
            r_ch    <= '0;
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            if (w_pad) begin
              r_ch <= '0;
              if (r_pix == PIX_W'(NPIX-1)) begin
                r_state <= S_DRAIN;
              end else begin
                r_pix <= r_pix + 1'b1;
              end
            end else begin
              r_ch <= r_ch + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_smp == PIX_W'(NPIX)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          // An ack wins over a coincident start: the start is simply dropped.
          if (bus.done_ack_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_pix   <= '0;
            r_ch    <= '0;
            r_smp   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ifm_rd_en_o   = w_read;
  assign bus.ifm_rd_addr_o = w_read ? w_addr : '0;
  assign bus.layer_en_o    = r_layer_en;
  assign bus.ifm_o         = w_ifm;
  assign bus.ofm_wr_en_o   = r_wr_en;
  assign bus.ofm_wr_addr_o = r_wr_addr;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;

endmodule

// File: tb/tb_fire_expand_sequencer.sv
// Bench for fire_expand_sequencer: small (2x2, 3ch) instance with scoreboard and
// vector table, plus a default-parameter instance run end to end.
module tb_fire_expand_sequencer;

  localparam int S_WOUT   = 2;
  localparam int S_CHIN   = 3;
  localparam int S_ADDR_W = $clog2(S_WOUT*S_WOUT*S_CHIN);
  localparam int S_PIX_W  = $clog2(S_WOUT*S_WOUT)+1;
  localparam int B_WOUT   = 8;
  localparam int B_CHIN   = 112;
  localparam int B_ADDR_W = $clog2(B_WOUT*B_WOUT*B_CHIN);
  localparam int B_PIX_W  = $clog2(B_WOUT*B_WOUT)+1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fire_expand_sequencer_if #(.WIDTH(16), .ADDR_W(S_ADDR_W), .PIX_W(S_PIX_W)) sb ();
  fire_expand_sequencer_if #(.WIDTH(16), .ADDR_W(B_ADDR_W), .PIX_W(B_PIX_W)) bb ();

  fire_expand_sequencer #(
    .WOUT(S_WOUT), .CHIN(S_CHIN), .WIDTH(16), .ADDR_W(S_ADDR_W), .PIX_W(S_PIX_W)
  ) u_small (.clk(clk), .rst(rst), .bus(sb.slave));

  fire_expand_sequencer #(
    .WOUT(B_WOUT), .CHIN(B_CHIN), .WIDTH(16), .ADDR_W(B_ADDR_W), .PIX_W(B_PIX_W)
  ) u_big (.clk(clk), .rst(rst), .bus(bb.slave));

  // Feature RAMs return their read address as data, one cycle after the strobe.
  always @(posedge clk) if (sb.ifm_rd_en_o) sb.ifm_rd_data_i <= 16'(sb.ifm_rd_addr_o);
  always @(posedge clk) if (bb.ifm_rd_en_o) bb.ifm_rd_data_i <= 16'(bb.ifm_rd_addr_o);

  typedef struct {
    int stall_at;
    int stall_len;
    int smp0;
    int smp_step;
    int extra_start;
    int ack_mode;
    int exp_first;
    int exp_en;
    int exp_rd;
    int exp_wr;
    int exp_gaps;
  } vec_t;

  vec_t vecs[4];

  int total = 0;
  int bad   = 0;

  int q_addr[$];
  int q_beat[$];
  int q_wr[$];
  bit mon_en = 1'b0;
  bit big_mon = 1'b0;
  bit prev_smp = 1'b0;
  int n_rd, n_en, n_wr, en_first, en_last;
  int b_rd, b_en, b_wr, b_last_addr;
  int start_cyc;

  function automatic void chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        if (sb.ifm_rd_en_o) begin
          n_rd++;
          if (q_addr.size() == 0) chk("rd_unexpected", sb.ifm_rd_en_o, 0);
          else chk("rd_addr", sb.ifm_rd_addr_o, q_addr.pop_front());
        end
        if (sb.layer_en_o) begin
          n_en++;
          if (n_en == 1) en_first = cyc;
          en_last = cyc;
          if (q_beat.size() == 0) chk("en_unexpected", sb.layer_en_o, 0);
          else chk("ifm_o", sb.ifm_o, q_beat.pop_front());
        end
        if (sb.ofm_wr_en_o) begin
          n_wr++;
          chk("wr_after_sample", prev_smp, 1);
          if (q_wr.size() == 0) chk("wr_unexpected", sb.ofm_wr_en_o, 0);
          else chk("wr_addr", sb.ofm_wr_addr_o, q_wr.pop_front());
        end
        prev_smp = sb.layer_sample_i;
      end
      if (big_mon) begin
        if (bb.ifm_rd_en_o) begin
          b_rd++;
          b_last_addr = int'(bb.ifm_rd_addr_o);
        end
        if (bb.layer_en_o) b_en++;
        if (bb.ofm_wr_en_o) b_wr++;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd_en"},    sb.ifm_rd_en_o,   0);
    chk({tag, "_rd_addr"},  sb.ifm_rd_addr_o, 0);
    chk({tag, "_layer_en"}, sb.layer_en_o,    0);
    chk({tag, "_ifm_o"},    sb.ifm_o,         0);
    chk({tag, "_wr_en"},    sb.ofm_wr_en_o,   0);
    chk({tag, "_wr_addr"},  sb.ofm_wr_addr_o, 0);
    chk({tag, "_busy"},     sb.busy_o,        0);
    chk({tag, "_done"},     sb.done_o,        0);
  endtask

  task automatic clear_stats();
    q_addr.delete();
    q_beat.delete();
    q_wr.delete();
    n_rd = 0; n_en = 0; n_wr = 0; en_first = 0; en_last = 0;
    prev_smp = 1'b0;
  endtask

  task automatic run_layer(input vec_t v);
    int nsmp;
    clear_stats();
    for (int p = 0; p < S_WOUT*S_WOUT; p++) begin
      for (int c = 0; c < S_CHIN; c++) begin
        q_addr.push_back(p*S_CHIN + c);
        q_beat.push_back(p*S_CHIN + c);
      end
      q_beat.push_back(0);
    end
    @(negedge clk);
    chk("busy_before_start", sb.busy_o, 0);
    sb.start_i = 1'b1;
    start_cyc = cyc;
    nsmp = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) chk("busy_running", sb.busy_o, 1);
      sb.start_i        = (k == v.extra_start);
      sb.ifm_stall_i    = (k >= v.stall_at) && (k < v.stall_at + v.stall_len);
      sb.layer_sample_i = 1'b0;
      if (nsmp < 4 && k == v.smp0 + nsmp*v.smp_step) begin
        sb.layer_sample_i = 1'b1;
        q_wr.push_back(nsmp);
        nsmp++;
      end
    end
    @(negedge clk);
    sb.start_i = 1'b0; sb.ifm_stall_i = 1'b0; sb.layer_sample_i = 1'b0;
    for (int i = 0; i < 50 && !sb.done_o; i++) @(negedge clk);
    chk("done_set",     sb.done_o, 1);
    chk("busy_in_done", sb.busy_o, 0);
    chk("first_en_lat", en_first - start_cyc, v.exp_first);
    chk("en_beats",     n_en, v.exp_en);
    chk("rd_count",     n_rd, v.exp_rd);
    chk("wr_count",     n_wr, v.exp_wr);
    chk("en_gaps",      (en_last - en_first + 1) - n_en, v.exp_gaps);
    chk("q_left",       q_addr.size() + q_beat.size() + q_wr.size(), 0);

    if (v.ack_mode == 0) begin
      repeat (2) @(negedge clk);
      chk("done_hold", sb.done_o, 1);
      sb.done_ack_i = 1'b1;
      @(negedge clk);
      sb.done_ack_i = 1'b0;
    end else begin
      // Sample while DONE must be ignored, then start+ack together.
      sb.layer_sample_i = 1'b1;
      @(negedge clk);
      sb.layer_sample_i = 1'b0;
      chk("done_hold_smp", sb.done_o, 1);
      sb.start_i = 1'b1;
      sb.done_ack_i = 1'b1;
      @(negedge clk);
      sb.start_i = 1'b0;
      sb.done_ack_i = 1'b0;
    end
    chk("done_cleared", sb.done_o, 0);
    chk("busy_after_ack", sb.busy_o, 0);
    repeat (5) @(negedge clk);
    chk("no_second_run", sb.busy_o, 0);
    chk("wr_after_ack", n_wr, v.exp_wr);
  endtask

  initial begin
    // stall_at, stall_len, smp0, smp_step, extra_start, ack_mode, first, en, rd, wr, gaps
    vecs[0] = '{-1, 0,  4, 4,  6, 0, 2, 16, 12, 4, 0};
    vecs[1] = '{ 9, 3, 20, 2, -1, 1, 2, 16, 12, 4, 3};
    vecs[2] = '{ 7, 2,  5, 8, 10, 0, 2, 16, 12, 4, 2};
    vecs[3] = '{ 3, 1,  2, 1, -1, 0, 2, 16, 12, 4, 1};

    sb.start_i = 1'b0; sb.ifm_stall_i = 1'b0; sb.layer_sample_i = 1'b0; sb.done_ack_i = 1'b0;
    bb.start_i = 1'b0; bb.ifm_stall_i = 1'b0; bb.layer_sample_i = 1'b0; bb.done_ack_i = 1'b0;

    fork
      monitor_loop();
    join_none

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) run_layer(vecs[i]);

    // Asynchronous abort mid-stream, then a fresh run from address 0.
    mon_en = 1'b0;
    @(negedge clk);
    sb.start_i = 1'b1;
    @(negedge clk);
    sb.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_busy", sb.busy_o, 1);
    rst = 1'b0;
    #1;
    chk_idle("abort");
    repeat (2) @(negedge clk);
    chk_idle("abort_hold");
    rst = 1'b1;
    @(negedge clk);
    clear_stats();
    mon_en = 1'b1;
    run_layer(vecs[0]);
    mon_en = 1'b0;

    // Default-size layer end to end.
    b_rd = 0; b_en = 0; b_wr = 0; b_last_addr = -1;
    big_mon = 1'b1;
    @(negedge clk);
    bb.start_i = 1'b1;
    @(negedge clk);
    bb.start_i = 1'b0;
    for (int i = 0; i < 9000 && !bb.done_o; i++) begin
      bb.layer_sample_i = (i % 100 == 50) && (i < 6400);
      @(negedge clk);
    end
    bb.layer_sample_i = 1'b0;
    chk("big_done",      bb.done_o, 1);
    chk("big_rd_count",  b_rd, B_WOUT*B_WOUT*B_CHIN);
    chk("big_en_beats",  b_en, B_WOUT*B_WOUT*(B_CHIN+1));
    chk("big_wr_count",  b_wr, B_WOUT*B_WOUT);
    chk("big_last_addr", b_last_addr, B_WOUT*B_WOUT*B_CHIN - 1);
    bb.done_ack_i = 1'b1;
    @(negedge clk);
    bb.done_ack_i = 1'b0;
    chk("big_done_ack", bb.done_o, 0);
    big_mon = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
